contador_varredura_m: RTL and testbench
=======================================

CONTADOR_VARREDURA_M -- requirements
Module: contador_varredura_m

Interface
REQ-001 SHALL have parameter N, default 6, meaning counter/limit width in bits.
REQ-002 SHALL have parameter S, default 3, meaning step (passo) width in bits.
REQ-003 SHALL have parameter P, default 4, meaning dwell (pausa) width in bits.
REQ-004 SHALL have port clock  in  1  meaning sole clock, all state on rising edge.
REQ-005 SHALL have port zera_s  in  1  meaning reset, synchronous, active-high.
REQ-006 SHALL have port conta  in  1  meaning count enable, one step per enabled cycle.
REQ-007 SHALL have port carrega  in  1  meaning synchronous load of valor_carga.
REQ-008 SHALL have port valor_carga  in  N  meaning load value.
REQ-009 SHALL have port modo  in  2  meaning 00 up-wrap, 01 down-wrap, 10 ping-pong, 11 treated as ping-pong.
REQ-010 SHALL have port passo  in  S  meaning step size; 0 treated as 1.
REQ-011 SHALL have ports lim_inf and lim_sup  in  N each  meaning inclusive runtime bounds.
REQ-012 SHALL have port pausa  in  P  meaning dwell cycles at a bound; present in all builds.
REQ-013 SHALL have port Q  out  N  meaning registered count.
REQ-014 SHALL have port direcao  out  1  meaning 0 counting up, 1 counting down.
REQ-015 SHALL have ports inicio, fim, meio  out  1 each  meaning combinational Q==lim_inf, Q==lim_sup, Q==floor((lim_inf+lim_sup)/2), sum in N+1 bits.
REQ-016 SHALL have port virada  out  1  meaning registered one-cycle pulse on direction reversal or wrap.
REQ-017 SHALL have port erro  out  1  meaning combinational lim_inf>lim_sup.

Function
REQ-018 Priority SHALL be zera_s > carrega > conta; with none active, all state holds and virada=0.
REQ-019 carrega SHALL set Q to valor_carga clamped into [lim_inf,lim_sup], keep direcao, cancel any dwell, and not pulse virada.
REQ-020 While erro=1, conta and carrega SHALL be ignored; Q and direcao hold.
REQ-021 On conta with Q outside [lim_inf,lim_sup], Q SHALL clamp to the nearer bound, no virada, no dwell.
REQ-022 Up step: if Q==lim_sup then up-wrap sets Q=lim_inf with virada=1, ping-pong sets Q=max(lim_sup-passo,lim_inf) with direcao=1 and virada=1; else Q=min(Q+passo,lim_sup), sum in N+1 bits.
REQ-023 Down step: if Q==lim_inf then down-wrap sets Q=lim_sup with virada=1, ping-pong sets Q=min(lim_inf+passo,lim_sup) with direcao=0 and virada=1; else Q=max(Q-passo,lim_inf), no underflow.
REQ-024 modo SHALL be sampled each step: up-wrap forces direcao=0, down-wrap forces direcao=1, ping-pong keeps current direcao.
REQ-025 lim_inf==lim_sup SHALL hold Q at the bound with no virada and direcao unchanged.
REQ-026 FSM states SHALL be SUBINDO, DESCENDO, and PAUSA (macro builds only); direcao=1 exactly in DESCENDO, or in PAUSA entered from DESCENDO.

Reset
REQ-027 zera_s SHALL set Q=0, direcao=0, virada=0, state SUBINDO, dwell counter 0, overriding all inputs in the same cycle.

Configuration
REQ-028 With CONTADOR_VARREDURA_PAUSA_EN defined: after a step lands Q on lim_inf or lim_sup, including via wrap, the FSM SHALL enter PAUSA and hold Q for pausa further conta cycles, then resume; pausa=0 SHALL add no cycles.
REQ-029 Without CONTADOR_VARREDURA_PAUSA_EN: there SHALL be no PAUSA state, the pausa port SHALL be ignored, and stepping SHALL be continuous.

Structure
REQ-030 Package contador_pkg SHALL hold the modo encodings (MODO_SOBE, MODO_DESCE, MODO_VAIVEM) and the FSM state typedef.
REQ-031 The dwell down-counter SHALL be sub-module contador_pausa_m, instantiated only under the macro.

Verification (N=6, S=3, P=4)
REQ-032 modo=10, bounds 0..49, passo=1, conta held after reset -> Q 0..49, 48 with direcao=1 and virada pulse, down to 0, then 1 with direcao=0 and virada pulse.
REQ-033 modo=00, bounds 10..20, passo=3, from reset -> Q 10,13,16,19,20,10 with virada only on the 20->10 step.
REQ-034 modo=01, bounds 5..9, passo=2, load 9 -> Q 9,7,5,9 with direcao=1 throughout and virada on 5->9.
REQ-035 lim_inf=30, lim_sup=20 -> erro=1, Q holds for 10 conta cycles; zera_s with carrega same cycle -> Q=0; load 60 with bounds 0..49 -> Q=49.
REQ-036 Macro defined, modo=10, bounds 0..3, passo=1, pausa=3 -> Q=3 held for 4 total conta cycles, then Q=2 with virada pulse.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared encodings for the sweep counter.
// The PAUSA dwell state exists only when CONTADOR_VARREDURA_PAUSA_EN is defined.
package contador_pkg;

    localparam logic [1:0] MODO_SOBE   = 2'b00;
    localparam logic [1:0] MODO_DESCE  = 2'b01;
    localparam logic [1:0] MODO_VAIVEM = 2'b10;

`ifdef CONTADOR_VARREDURA_PAUSA_EN
    typedef enum logic [1:0] {SUBINDO, DESCENDO, PAUSA} estado_e;
`else
    typedef enum logic [0:0] {SUBINDO, DESCENDO} estado_e;
`endif

endpackage

// File: rtl/contador_pausa_m.sv
// Dwell down-counter: loaded on arrival at a bound, decremented on each held conta cycle.
module contador_pausa_m #(
    parameter int unsigned P = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [P-1:0] load_val_i,
    input  logic         dec_i,
    output logic         ultimo_o
);

    logic [P-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - P'(1);
        end
    end

    // High on the final held cycle; the FSM leaves PAUSA on this one.
    assign ultimo_o = (cnt_q == P'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/contador_varredura_m.sv
// Bounded sweep counter (up-wrap, down-wrap, ping-pong) with runtime limits and step.
// Optional dwell at the bounds is enabled by defining CONTADOR_VARREDURA_PAUSA_EN.
module contador_varredura_m
    import contador_pkg::*;
#(
    parameter int unsigned N = 6,
    parameter int unsigned S = 3,
    parameter int unsigned P = 4
) (
    input  logic         clock,
    input  logic         zera_s,
    input  logic         conta,
    input  logic         carrega,
    input  logic [N-1:0] valor_carga,
    input  logic [1:0]   modo,
    input  logic [S-1:0] passo,
    input  logic [N-1:0] lim_inf,
    input  logic [N-1:0] lim_sup,
    input  logic [P-1:0] pausa,
    output logic [N-1:0] Q,
    output logic         direcao,
    output logic         inicio,
    output logic         fim,
    output logic         meio,
    output logic         virada,
    output logic         erro
);

    localparam int unsigned W = N + 1;

    estado_e      state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic         virada_q, virada_d;
    logic         dir_atual, dir_novo, sobe, vaivem, fora;
    logic [N:0]   passo_x, inf_x, sup_x, q_x, soma_x, inf_passo_x, meio_x;
    logic [N-1:0] sobe_prox, desce_prox, pp_topo, pp_base, carga_lim, q_lim;

    // Widened arithmetic so sums never wrap and differences never underflow.
    assign passo_x     = (passo == '0) ? W'(1) : W'(passo);
    assign inf_x       = {1'b0, lim_inf};
    assign sup_x       = {1'b0, lim_sup};
    assign q_x         = {1'b0, q_q};
    assign soma_x      = q_x + passo_x;
    assign inf_passo_x = inf_x + passo_x;
    assign meio_x      = (inf_x + sup_x) >> 1;

    assign sobe_prox  = (soma_x > sup_x) ? lim_sup : soma_x[N-1:0];
    assign desce_prox = (q_x < inf_passo_x) ? lim_inf : (q_q - passo_x[N-1:0]);
    assign pp_topo    = (sup_x < inf_passo_x) ? lim_inf : (lim_sup - passo_x[N-1:0]);
    assign pp_base    = (inf_passo_x > sup_x) ? lim_sup : inf_passo_x[N-1:0];

    assign carga_lim = (valor_carga < lim_inf) ? lim_inf :
                       (valor_carga > lim_sup) ? lim_sup : valor_carga;
    assign q_lim     = (q_q < lim_inf) ? lim_inf : lim_sup;
    assign fora      = (q_q < lim_inf) || (q_q > lim_sup);

    assign erro   = (lim_inf > lim_sup);
    assign inicio = (q_q == lim_inf);
    assign fim    = (q_q == lim_sup);
    assign meio   = (q_x == meio_x);
    assign Q      = q_q;
    assign virada = virada_q;

    always_comb begin
        sobe   = ~dir_atual;
        vaivem = 1'b1;
        case (modo)
            MODO_SOBE: begin
                sobe   = 1'b1;
                vaivem = 1'b0;
            end
            MODO_DESCE: begin
                sobe   = 1'b0;
                vaivem = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef CONTADOR_VARREDURA_PAUSA_EN
    logic pdir_q, pdir_d;
    logic pausa_clr, pausa_load, pausa_dec, pausa_ultimo;

    assign dir_atual = (state_q == DESCENDO) || ((state_q == PAUSA) && pdir_q);

    contador_pausa_m #(
        .P (P)
    ) u_pausa (
        .clk_i      (clock),
        .rst_i      (zera_s),
        .clear_i    (pausa_clr),
        .load_i     (pausa_load),
        .load_val_i (pausa),
        .dec_i      (pausa_dec),
        .ultimo_o   (pausa_ultimo)
    );

    always_ff @(posedge clock) begin
        if (zera_s) begin
            pdir_q <= 1'b0;
        end else begin
            pdir_q <= pdir_d;
        end
    end
`else
    logic unused_pausa;

    assign unused_pausa = ^pausa;
    assign dir_atual    = (state_q == DESCENDO);
`endif

    assign direcao = dir_atual;

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        virada_d = 1'b0;
        dir_novo = dir_atual;
`ifdef CONTADOR_VARREDURA_PAUSA_EN
        pdir_d     = pdir_q;
        pausa_clr  = 1'b0;
        pausa_load = 1'b0;
        pausa_dec  = 1'b0;
`endif
        if (!erro) begin
            if (carrega) begin
                q_d     = carga_lim;
                state_d = dir_atual ? DESCENDO : SUBINDO;
`ifdef CONTADOR_VARREDURA_PAUSA_EN
                pausa_clr = 1'b1;
`endif
            end else if (conta) begin
                if (fora) begin
                    q_d     = q_lim;
                    state_d = dir_atual ? DESCENDO : SUBINDO;
`ifdef CONTADOR_VARREDURA_PAUSA_EN
                    pausa_clr = 1'b1;
                end else if (state_q == PAUSA) begin
                    pausa_dec = 1'b1;
                    if (pausa_ultimo) begin
                        state_d = pdir_q ? DESCENDO : SUBINDO;
                    end
`endif
                end else if (lim_inf != lim_sup) begin
                    if (sobe) begin
                        dir_novo = 1'b0;
                        if (q_q == lim_sup) begin
                            virada_d = 1'b1;
                            q_d      = vaivem ? pp_topo : lim_inf;
                            dir_novo = vaivem;
                        end else begin
                            q_d = sobe_prox;
                        end
                    end else begin
                        dir_novo = 1'b1;
                        if (q_q == lim_inf) begin
                            virada_d = 1'b1;
                            q_d      = vaivem ? pp_base : lim_sup;
                            dir_novo = ~vaivem;
                        end else begin
                            q_d = desce_prox;
                        end
                    end
                    state_d = dir_novo ? DESCENDO : SUBINDO;
`ifdef CONTADOR_VARREDURA_PAUSA_EN
                    if (((q_d == lim_inf) || (q_d == lim_sup)) && (pausa != '0)) begin
                        state_d    = PAUSA;
                        pdir_d     = dir_novo;
                        pausa_load = 1'b1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (zera_s) begin
            state_q  <= SUBINDO;
            q_q      <= '0;
            virada_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            virada_q <= virada_d;
        end
    end

endmodule

// File: tb/tb_contador_varredura_m.sv
// Self-checking bench for contador_varredura_m: integer reference model plus directed vectors.
// The dwell scenario runs only when CONTADOR_VARREDURA_PAUSA_EN is defined.
module tb_contador_varredura_m;

    localparam int N = 6;
    localparam int S = 3;
    localparam int P = 4;
`ifdef CONTADOR_VARREDURA_PAUSA_EN
    localparam bit PAUSA_EN = 1'b1;
`else
    localparam bit PAUSA_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         zera_s = 1'b1;
    logic         conta = 1'b0;
    logic         carrega = 1'b0;
    logic [N-1:0] valor_carga = '0;
    logic [1:0]   modo = 2'b00;
    logic [S-1:0] passo = '0;
    logic [N-1:0] lim_inf = '0;
    logic [N-1:0] lim_sup = '0;
    logic [P-1:0] pausa = '0;
    logic [N-1:0] Q;
    logic         direcao, inicio, fim, meio, virada, erro;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int m_q, m_dir, m_vir, m_dwell;

    always #5 clock = ~clock;

    contador_varredura_m #(
        .N (N),
        .S (S),
        .P (P)
    ) dut (
        .clock       (clock),
        .zera_s      (zera_s),
        .conta       (conta),
        .carrega     (carrega),
        .valor_carga (valor_carga),
        .modo        (modo),
        .passo       (passo),
        .lim_inf     (lim_inf),
        .lim_sup     (lim_sup),
        .pausa       (pausa),
        .Q           (Q),
        .direcao     (direcao),
        .inicio      (inicio),
        .fim         (fim),
        .meio        (meio),
        .virada      (virada),
        .erro        (erro)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference model in plain integers, updated on each rising edge from the sampled inputs.
    always @(posedge clock) begin
        int inf, sup, p;
        bit up;
        inf = int'(lim_inf);
        sup = int'(lim_sup);
        p   = (passo == 0) ? 1 : int'(passo);
        m_vir = 0;
        if (zera_s) begin
            m_q = 0; m_dir = 0; m_dwell = 0;
        end else if (inf > sup) begin
        end else if (carrega) begin
            m_q = clamp(int'(valor_carga), inf, sup);
            m_dwell = 0;
        end else if (conta) begin
            if (m_q < inf || m_q > sup) begin
                m_q = clamp(m_q, inf, sup);
                m_dwell = 0;
            end else if (m_dwell > 0) begin
                m_dwell--;
            end else if (inf != sup) begin
                up = (modo == 2'b00) ? 1'b1 : (modo == 2'b01) ? 1'b0 : (m_dir == 0);
                if (up) begin
                    if (m_q == sup) begin
                        m_vir = 1;
                        if (modo[1]) begin m_q = clamp(sup - p, inf, sup); m_dir = 1; end
                        else begin m_q = inf; m_dir = 0; end
                    end else begin
                        m_q = clamp(m_q + p, inf, sup); m_dir = 0;
                    end
                end else begin
                    if (m_q == inf) begin
                        m_vir = 1;
                        if (modo[1]) begin m_q = clamp(inf + p, inf, sup); m_dir = 0; end
                        else begin m_q = sup; m_dir = 1; end
                    end else begin
                        m_q = clamp(m_q - p, inf, sup); m_dir = 1;
                    end
                end
                if (PAUSA_EN && (m_q == inf || m_q == sup)) m_dwell = int'(pausa);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmp.Q", int'(Q), m_q);
            check("cmp.direcao", int'(direcao), m_dir);
            check("cmp.virada", int'(virada), m_vir);
            check("cmp.inicio", int'(inicio), int'(m_q == int'(lim_inf)));
            check("cmp.fim", int'(fim), int'(m_q == int'(lim_sup)));
            check("cmp.meio", int'(meio), int'(m_q == (int'(lim_inf) + int'(lim_sup)) / 2));
            check("cmp.erro", int'(erro), int'(int'(lim_inf) > int'(lim_sup)));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string nm, input int q, input int d, input int v);
        check({nm, ".Q"}, int'(Q), q);
        check({nm, ".direcao"}, int'(direcao), d);
        check({nm, ".virada"}, int'(virada), v);
    endtask

    task automatic do_reset();
        zera_s = 1'b1; conta = 1'b0; carrega = 1'b0;
        tick();
        zera_s = 1'b0;
    endtask

    initial begin
        // Ping-pong 0..49, step 1
        do_reset();
        chk_en = 1'b1;
        expect_out("reset", 0, 0, 0);
        modo = 2'b10; lim_inf = 6'd0; lim_sup = 6'd49; passo = 3'd1; conta = 1'b1;
        for (int i = 1; i <= 49; i++) begin
            tick();
            expect_out("pp_up", i, 0, 0);
        end
        tick();
        expect_out("pp_turn_top", 48, 1, 1);
        for (int i = 47; i >= 0; i--) begin
            tick();
            expect_out("pp_down", i, 1, 0);
        end
        tick();
        expect_out("pp_turn_bot", 1, 0, 1);

        // Up-wrap 10..20, step 3, first step clamps from 0
        do_reset();
        modo = 2'b00; lim_inf = 6'd10; lim_sup = 6'd20; passo = 3'd3; conta = 1'b1;
        tick(); expect_out("upw_clamp", 10, 0, 0);
        tick(); expect_out("upw_13", 13, 0, 0);
        tick(); expect_out("upw_16", 16, 0, 0);
        tick(); expect_out("upw_19", 19, 0, 0);
        tick(); expect_out("upw_20", 20, 0, 0);
        tick(); expect_out("upw_wrap", 10, 0, 1);

        // Down-wrap 5..9, step 2
        do_reset();
        modo = 2'b01; lim_inf = 6'd5; lim_sup = 6'd9; passo = 3'd2;
        carrega = 1'b1; valor_carga = 6'd7;
        tick(); expect_out("dnw_load7", 7, 0, 0);
        carrega = 1'b0; conta = 1'b1;
        tick(); expect_out("dnw_5", 5, 1, 0);
        conta = 1'b0; carrega = 1'b1; valor_carga = 6'd9;
        tick(); expect_out("dnw_load9", 9, 1, 0);
        carrega = 1'b0; conta = 1'b1;
        tick(); expect_out("dnw_7", 7, 1, 0);
        tick(); expect_out("dnw_5b", 5, 1, 0);
        tick(); expect_out("dnw_wrap", 9, 1, 1);

        // Inverted bounds: everything frozen
        lim_inf = 6'd30; lim_sup = 6'd20;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("erro_hold", 9, 1, 0);
            check("erro_flag", int'(erro), 1);
        end
        zera_s = 1'b1; carrega = 1'b1; valor_carga = 6'd40;
        tick(); expect_out("zera_over_load", 0, 0, 0);
        zera_s = 1'b0; conta = 1'b0; lim_inf = 6'd0; lim_sup = 6'd49; valor_carga = 6'd60;
        tick(); expect_out("load_clamp_hi", 49, 0, 0);
        check("erro_clear", int'(erro), 0);

        // passo=0 behaves as 1; load below range clamps up
        modo = 2'b00; valor_carga = 6'd45;
        tick(); expect_out("load45", 45, 0, 0);
        carrega = 1'b0; conta = 1'b1; passo = 3'd0;
        tick(); expect_out("passo0", 46, 0, 0);
        conta = 1'b0; carrega = 1'b1; lim_inf = 6'd10; lim_sup = 6'd20; valor_carga = 6'd3;
        tick(); expect_out("load_clamp_lo", 10, 0, 0);

        // Equal bounds: clamp once, then hold without virada
        carrega = 1'b0; conta = 1'b1; modo = 2'b10; lim_inf = 6'd25; lim_sup = 6'd25;
        tick(); expect_out("eq_clamp", 25, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("eq_hold", 25, 0, 0);
        end

        // Midpoint needs the wide sum near the top of the range
        conta = 1'b0; carrega = 1'b1; lim_inf = 6'd60; lim_sup = 6'd63; valor_carga = 6'd61;
        tick();
        check("meio_hi", int'(meio), 1);
        check("fim_lo", int'(fim), 0);
        carrega = 1'b0;

`ifdef CONTADOR_VARREDURA_PAUSA_EN
        // Dwell of 3 extra conta cycles at the top of 0..3
        do_reset();
        modo = 2'b10; lim_inf = 6'd0; lim_sup = 6'd3; passo = 3'd1; pausa = 4'd3; conta = 1'b1;
        tick(); expect_out("dw_1", 1, 0, 0);
        tick(); expect_out("dw_2", 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("dw_hold3", 3, 0, 0);
        end
        tick(); expect_out("dw_turn", 2, 1, 1);
        pausa = 4'd0;
`endif

        tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
